commit_ctrl: RTL and testbench
==============================

# commit_ctrl

Parametrised in-order commit controller that sits between the ROB head and the architectural-state and redirect logic. Each cycle it selects the longest legal prefix of up to COMMIT_WIDTH head entries. It forces serialising entries (first_commit) and flush-causing entries to commit alone. It then sequences a registered flush/redirect followed by a programmable drain window, and it keeps a 64-bit retired-instruction count.

## Interface
Parameters:
- COMMIT_WIDTH, 2, number of ROB head slots examined per cycle; legal range 1..4
- DRAIN_CYCLES, 2, idle cycles after the flush pulse before commits resume; 0 is legal

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous reset, active-high (1 = reset)
- rob_commit_i  input  COMMIT_WIDTH x rob_commit_pkg_t  ROB head slots, slot 0 oldest; fields used: c_valid, first_commit, flush_req, redirect_pc[31:0]
- commit_ready_i  input  1  downstream (regfile/store buffer) can accept commits this cycle
- commit_request_o  output  COMMIT_WIDTH  per-slot commit strobe; slot k retires when bit k = 1
- flush_o  output  1  one-cycle pipeline flush pulse
- redirect_pc_o  output  32  fetch redirect target; valid while flush_o = 1
- retire_cnt_o  output  64  running count of committed entries

## Operation
- FSM states: NORMAL, FLUSH, DRAIN. Reset state is NORMAL.
- Candidate selection in NORMAL:
  - Slot 0 is a candidate if c_valid.
  - Slot k>0 is a candidate if slot k-1 is a candidate, slot k c_valid, and none of slots 0..k have first_commit or flush_req set.
  - A slot 0 with first_commit or flush_req is therefore committed alone.
  - A serialising entry at k>0 blocks slots k and above; it waits until it reaches slot 0.
- commit_request_o = candidates & {COMMIT_WIDTH{commit_ready_i}} in NORMAL. It is all-zero in FLUSH and DRAIN.
- Selection is strictly a prefix: no bit k is set unless bits 0..k-1 are set.
- Flush trigger: commit_request_o[0] = 1 and rob_commit_i[0].flush_req = 1. Next state is FLUSH, and redirect_pc_o is loaded from slot 0 redirect_pc.
- FLUSH: flush_o = 1 for exactly this cycle. Next state is DRAIN if DRAIN_CYCLES > 0, otherwise NORMAL.
- DRAIN: a down-counter is loaded with DRAIN_CYCLES on entry. The state exits to NORMAL in the cycle after the counter reads 1. The counter is $clog2(DRAIN_CYCLES+1) bits wide, minimum 1 bit.
- retire_cnt_o increments by popcount(commit_request_o) each cycle and wraps modulo 2^64.
- A flush_req with commit_ready_i = 0 does not trigger. The entry is held and retried.

## Timing
- commit_request_o: combinational from rob_commit_i, commit_ready_i and FSM state; zero latency.
- flush_o, redirect_pc_o: registered. The flush pulse appears 1 cycle after the committing edge. flush_o is never high for 2 consecutive cycles.
- First commit after a flush: cycle 2 + DRAIN_CYCLES after the flush-causing commit.
- retire_cnt_o: registered; reflects commits up to the previous cycle.
- Reset values: state NORMAL, flush_o 0, redirect_pc_o 0, retire_cnt_o 0, drain counter 0. commit_request_o is 0 during reset.
- Reset asserted mid-FLUSH or mid-DRAIN aborts immediately. No flush pulse follows deassertion.
- COMMIT_WIDTH = 1: one commit per cycle at most; flush behaviour is unchanged.

## Structure
- rob_commit_pkg_t, including the added flush_req and redirect_pc fields, lives in the shared defines package. The commit FSM state enum is defined in the same package.
- Sub-module commit_prefix_sel: purely combinational candidate/prefix selection over COMMIT_WIDTH slots. The parent holds the FSM, drain counter, redirect register and retire counter.

## Test plan
- Width 2, both slots valid, no flags, ready = 1 → commit_request_o = 2'b11; retire_cnt_o goes 0→2 on the next cycle.
- Width 4, slot 2 first_commit = 1 → request 4'b0011. When that entry reaches slot 0 next cycle with slots 1..3 valid → request 4'b0001.
- Slot 0 flush_req, redirect_pc = 0x1C00_0040, DRAIN_CYCLES = 2:
  - commit cycle T: request = 2'b01.
  - T+1: flush_o = 1, redirect_pc_o = 0x1C00_0040.
  - T+2 and T+3: requests 0.
  - T+4: commits resume.
- Same as the previous scenario with DRAIN_CYCLES = 0 → flush_o at T+1, commits allowed again at T+2.
- Slot 0 flush_req with ready = 0 for 3 cycles, then ready = 1 → no flush and request 0 during the stall; the flush pulse follows the first ready cycle.
- Reset asserted during DRAIN → all outputs 0 immediately. After deassertion, a valid slot 0 commits in the first cycle without any flush_o.

Source files
------------

// File: rtl/commit_ctrl_pkg.sv
// Shared types for the in-order commit controller.
// ROB head slot layout, commit FSM states and small helpers.
package commit_ctrl_pkg;

    localparam int MAX_COMMIT_WIDTH = 4;
    localparam int POP_W            = 3;

    typedef struct packed {
        logic        c_valid;
        logic        first_commit;
        logic        flush_req;
        logic [31:0] redirect_pc;
    } rob_commit_pkg_t;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_DRAIN  = 2'd2
    } commit_state_e;

    function automatic logic [POP_W-1:0] popcnt4(
        input logic [MAX_COMMIT_WIDTH-1:0] v
    );
        logic [POP_W-1:0] s;
        s = '0;
        for (int i = 0; i < MAX_COMMIT_WIDTH; i++) begin
            s = s + POP_W'(v[i]);
        end
        return s;
    endfunction

endpackage

// File: rtl/commit_ctrl_if.sv
// ROB-head / commit-side bundle of the commit controller.
// master = ROB and downstream consumers, slave = controller.
interface commit_ctrl_if
    import commit_ctrl_pkg::*;
#(
    parameter int COMMIT_WIDTH = 2
);

    rob_commit_pkg_t [COMMIT_WIDTH-1:0] rob_commit_i;
    logic                               commit_ready_i;
    logic [COMMIT_WIDTH-1:0]            commit_request_o;
    logic                               flush_o;
    logic [31:0]                        redirect_pc_o;
    logic [63:0]                        retire_cnt_o;

    modport master (
        output rob_commit_i,
        output commit_ready_i,
        input  commit_request_o,
        input  flush_o,
        input  redirect_pc_o,
        input  retire_cnt_o
    );

    modport slave (
        input  rob_commit_i,
        input  commit_ready_i,
        output commit_request_o,
        output flush_o,
        output redirect_pc_o,
        output retire_cnt_o
    );

endinterface

// File: rtl/commit_prefix_sel.sv
// Combinational oldest-first prefix selection over the ROB head.
// A serialising slot commits only from slot 0 and then alone.
module commit_prefix_sel #(
    parameter int COMMIT_WIDTH = 2
) (
    input  logic [COMMIT_WIDTH-1:0] valid_i,
    input  logic [COMMIT_WIDTH-1:0] serial_i,
    output logic [COMMIT_WIDTH-1:0] cand_o
);

    logic blocked;

    // Walk slots oldest first; any serialising slot so far stops the chain.
    always_comb begin
        cand_o    = '0;
        blocked   = serial_i[0];
        cand_o[0] = valid_i[0];
        for (int k = 1; k < COMMIT_WIDTH; k++) begin
            blocked   = blocked | serial_i[k];
            cand_o[k] = cand_o[k-1] & valid_i[k] & ~blocked;
        end
    end

endmodule

// File: rtl/commit_ctrl.sv
// In-order commit controller: prefix commit, flush/redirect
// sequencing with a drain window, and a 64-bit retire counter.
module commit_ctrl
    import commit_ctrl_pkg::*;
#(
    parameter int COMMIT_WIDTH = 2,
    parameter int DRAIN_CYCLES = 2
) (
    input logic          clk,
    input logic          rst_n,
    commit_ctrl_if.slave bus
);

    localparam int CW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES);
    localparam logic [CW-1:0] DRAIN_ONE  = CW'(1);

    commit_state_e           state_q;
    commit_state_e           state_d;
    logic [CW-1:0]           drain_q;
    logic [CW-1:0]           drain_d;
    logic                    flush_q;
    logic                    flush_d;
    logic [31:0]             redirect_q;
    logic [31:0]             redirect_d;
    logic [63:0]             retire_cnt_q;
    logic [63:0]             retire_cnt_d;
    logic [COMMIT_WIDTH-1:0] valid_vec;
    logic [COMMIT_WIDTH-1:0] serial_vec;
    logic [COMMIT_WIDTH-1:0] cand;
    logic [COMMIT_WIDTH-1:0] req;
    logic [POP_W-1:0]        pop;
    logic                    trigger;
    logic                    unused_slots;

    // Younger slots' redirect targets are never consumed here.
    assign unused_slots = ^bus.rob_commit_i;

    // Split head slots into validity and serialising flags.
    always_comb begin
        valid_vec  = '0;
        serial_vec = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            valid_vec[k]  = bus.rob_commit_i[k].c_valid;
            serial_vec[k] = bus.rob_commit_i[k].first_commit
                          | bus.rob_commit_i[k].flush_req;
        end
    end

    commit_prefix_sel #(
        .COMMIT_WIDTH(COMMIT_WIDTH)
    ) u_sel (
        .valid_i (valid_vec),
        .serial_i(serial_vec),
        .cand_o  (cand)
    );

    // Commits only in NORMAL with downstream ready, never under reset.
    always_comb begin
        req = '0;
        if (!rst_n && state_q == ST_NORMAL && bus.commit_ready_i) begin
            req = cand;
        end
    end

    assign trigger = req[0] & bus.rob_commit_i[0].flush_req;
    assign pop     = popcnt4(MAX_COMMIT_WIDTH'(req));

    // Next-state logic for flush sequencing and drain window.
    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        flush_d    = 1'b0;
        redirect_d = redirect_q;
        unique case (state_q)
            ST_NORMAL: begin
                if (trigger) begin
                    state_d    = ST_FLUSH;
                    flush_d    = 1'b1;
                    redirect_d = bus.rob_commit_i[0].redirect_pc;
                end
            end
            ST_FLUSH: begin
                if (DRAIN_CYCLES > 0) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else begin
                    state_d = ST_NORMAL;
                end
            end
            ST_DRAIN: begin
                if (drain_q <= DRAIN_ONE) begin
                    state_d = ST_NORMAL;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q - DRAIN_ONE;
                end
            end
            default: begin
                state_d = ST_NORMAL;
                drain_d = '0;
            end
        endcase
    end

    // Retired-instruction count advances by the number of strobes.
    always_comb begin
        retire_cnt_d = retire_cnt_q + 64'(pop);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= ST_NORMAL;
            drain_q      <= '0;
            flush_q      <= 1'b0;
            redirect_q   <= '0;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            drain_q      <= drain_d;
            flush_q      <= flush_d;
            redirect_q   <= redirect_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign bus.commit_request_o = req;
    assign bus.flush_o          = flush_q;
    assign bus.redirect_pc_o    = redirect_q;
    assign bus.retire_cnt_o     = retire_cnt_q;

endmodule

// File: tb/tb_commit_ctrl.sv
// Bench for commit_ctrl: three configurations checked every cycle
// against a prefix/flush-window model plus literal expectations.
module tb_commit_ctrl;
    import commit_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    commit_ctrl_if #(.COMMIT_WIDTH(2)) if2 ();
    commit_ctrl_if #(.COMMIT_WIDTH(4)) if4 ();
    commit_ctrl_if #(.COMMIT_WIDTH(1)) if1 ();

    commit_ctrl #(.COMMIT_WIDTH(2), .DRAIN_CYCLES(2)) u2 (
        .clk(clk), .rst_n(rst), .bus(if2));
    commit_ctrl #(.COMMIT_WIDTH(4), .DRAIN_CYCLES(0)) u4 (
        .clk(clk), .rst_n(rst), .bus(if4));
    commit_ctrl #(.COMMIT_WIDTH(1), .DRAIN_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst), .bus(if1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Model state per instance: retired count, flush pending this
    // cycle, latched target, and commit-free cycles still owed.
    logic [63:0] m_cnt   [3];
    logic        m_flush [3];
    logic [31:0] m_pc    [3];
    int          m_hold  [3];

    task automatic model_cmp(
        input int id, input int w, input int d,
        input logic [3:0] v, input logic [3:0] fc, input logic [3:0] fr,
        input logic [31:0] pc0, input logic rdy,
        input logic [3:0] req, input logic fl,
        input logic [31:0] rpc, input logic [63:0] rc);
        int n;
        logic [3:0] er;
        n = 0;
        if (rst) begin
            m_cnt[id]   = '0;
            m_flush[id] = 1'b0;
            m_pc[id]    = '0;
            m_hold[id]  = 0;
            chk($sformatf("i%0d.rst_req", id), 64'(req), 64'h0);
            chk($sformatf("i%0d.rst_flush", id), 64'(fl), 64'h0);
            chk($sformatf("i%0d.rst_pc", id), 64'(rpc), 64'h0);
            chk($sformatf("i%0d.rst_cnt", id), rc, 64'h0);
        end else begin
            if (!m_flush[id] && m_hold[id] == 0 && rdy) begin
                for (int k = 0; k < w; k++) begin
                    if (!v[k]) break;
                    if (k > 0 && (fc[k] || fr[k])) break;
                    n++;
                    if (fc[k] || fr[k]) break;
                end
            end
            er = 4'((1 << n) - 1);
            chk($sformatf("i%0d.req", id), 64'(req), 64'(er));
            chk($sformatf("i%0d.flush", id), 64'(fl), 64'(m_flush[id]));
            chk($sformatf("i%0d.cnt", id), rc, m_cnt[id]);
            if (m_flush[id]) begin
                chk($sformatf("i%0d.pc", id), 64'(rpc), 64'(m_pc[id]));
            end
            m_cnt[id] = m_cnt[id] + 64'(n);
            if (m_flush[id]) m_hold[id] = d;
            else if (m_hold[id] > 0) m_hold[id] = m_hold[id] - 1;
            m_flush[id] = (n > 0) && fr[0];
            if (m_flush[id]) m_pc[id] = pc0;
        end
    endtask

    logic [3:0] gv, gfc, gfr;

    // Compare all three DUTs against the model on every falling edge.
    always @(negedge clk) begin
        gv = '0; gfc = '0; gfr = '0;
        for (int k = 0; k < 2; k++) begin
            gv[k]  = if2.rob_commit_i[k].c_valid;
            gfc[k] = if2.rob_commit_i[k].first_commit;
            gfr[k] = if2.rob_commit_i[k].flush_req;
        end
        model_cmp(0, 2, 2, gv, gfc, gfr, if2.rob_commit_i[0].redirect_pc,
                  if2.commit_ready_i, 4'(if2.commit_request_o),
                  if2.flush_o, if2.redirect_pc_o, if2.retire_cnt_o);
        gv = '0; gfc = '0; gfr = '0;
        for (int k = 0; k < 4; k++) begin
            gv[k]  = if4.rob_commit_i[k].c_valid;
            gfc[k] = if4.rob_commit_i[k].first_commit;
            gfr[k] = if4.rob_commit_i[k].flush_req;
        end
        model_cmp(1, 4, 0, gv, gfc, gfr, if4.rob_commit_i[0].redirect_pc,
                  if4.commit_ready_i, if4.commit_request_o,
                  if4.flush_o, if4.redirect_pc_o, if4.retire_cnt_o);
        gv = '0; gfc = '0; gfr = '0;
        gv[0]  = if1.rob_commit_i[0].c_valid;
        gfc[0] = if1.rob_commit_i[0].first_commit;
        gfr[0] = if1.rob_commit_i[0].flush_req;
        model_cmp(2, 1, 1, gv, gfc, gfr, if1.rob_commit_i[0].redirect_pc,
                  if1.commit_ready_i, 4'(if1.commit_request_o),
                  if1.flush_o, if1.redirect_pc_o, if1.retire_cnt_o);
    end

    function automatic rob_commit_pkg_t mk(input logic v, input logic fc,
                                           input logic fr,
                                           input logic [31:0] pc);
        rob_commit_pkg_t s;
        s.c_valid      = v;
        s.first_commit = fc;
        s.flush_req    = fr;
        s.redirect_pc  = pc;
        return s;
    endfunction

    task automatic clr_all();
        if2.rob_commit_i   = '0;
        if4.rob_commit_i   = '0;
        if1.rob_commit_i   = '0;
        if2.commit_ready_i = 1'b1;
        if4.commit_ready_i = 1'b1;
        if1.commit_ready_i = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] v;
        logic [3:0] fc;
        logic [3:0] fr;
        logic       rdy;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl [7];

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        tbl[0] = '{4'hF, 4'h0, 4'h0, 1'b1, 4'hF};
        tbl[1] = '{4'h7, 4'h0, 4'h0, 1'b1, 4'h7};
        tbl[2] = '{4'hB, 4'h0, 4'h0, 1'b1, 4'h3};
        tbl[3] = '{4'hF, 4'h2, 4'h0, 1'b1, 4'h1};
        tbl[4] = '{4'hF, 4'h0, 4'h0, 1'b0, 4'h0};
        tbl[5] = '{4'hE, 4'h0, 4'h0, 1'b1, 4'h0};
        tbl[6] = '{4'hF, 4'h0, 4'h8, 1'b1, 4'h7};

        rst = 1'b1;
        clr_all();
        if2.rob_commit_i[0] = mk(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.req", 64'(if2.commit_request_o), 64'h0);
        chk("rst.cnt", if2.retire_cnt_o, 64'h0);
        chk("rst.flush", 64'(if2.flush_o), 64'h0);
        step();
        rst = 1'b0;
        clr_all();
        step();

        // Two plain entries, width 2.
        if2.rob_commit_i[0] = mk(1'b1, 1'b0, 1'b0, 32'h0);
        if2.rob_commit_i[1] = mk(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("w2.both", 64'(if2.commit_request_o), 64'h3);
        chk("w2.cnt0", if2.retire_cnt_o, 64'd0);
        step();
        clr_all();
        @(negedge clk);
        chk("w2.cnt2", if2.retire_cnt_o, 64'd2);
        step();

        // Serialising entry at slot 2, then at slot 0.
        if4.rob_commit_i[0] = mk(1'b1, 1'b0, 1'b0, 32'h0);
        if4.rob_commit_i[1] = mk(1'b1, 1'b0, 1'b0, 32'h0);
        if4.rob_commit_i[2] = mk(1'b1, 1'b1, 1'b0, 32'h0);
        if4.rob_commit_i[3] = mk(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("w4.fc2", 64'(if4.commit_request_o), 64'h3);
        step();
        if4.rob_commit_i[0] = mk(1'b1, 1'b1, 1'b0, 32'h0);
        if4.rob_commit_i[1] = mk(1'b1, 1'b0, 1'b0, 32'h0);
        if4.rob_commit_i[2] = mk(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("w4.fc0", 64'(if4.commit_request_o), 64'h1);
        step();
        clr_all();
        @(negedge clk);
        chk("w4.cnt3", if4.retire_cnt_o, 64'd3);
        step();

        // Flush with a two-cycle drain window.
        if2.rob_commit_i[0] = mk(1'b1, 1'b0, 1'b1, 32'h1C00_0040);
        if2.rob_commit_i[1] = mk(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("fl2.T", 64'(if2.commit_request_o), 64'h1);
        step();
        if2.rob_commit_i[0] = mk(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("fl2.T1flush", 64'(if2.flush_o), 64'h1);
        chk("fl2.T1pc", 64'(if2.redirect_pc_o), 64'h1C00_0040);
        chk("fl2.T1req", 64'(if2.commit_request_o), 64'h0);
        step();
        @(negedge clk);
        chk("fl2.T2req", 64'(if2.commit_request_o), 64'h0);
        chk("fl2.T2flush", 64'(if2.flush_o), 64'h0);
        step();
        @(negedge clk);
        chk("fl2.T3req", 64'(if2.commit_request_o), 64'h0);
        step();
        @(negedge clk);
        chk("fl2.T4req", 64'(if2.commit_request_o), 64'h3);
        step();
        clr_all();

        // Flush with no drain window, width 4.
        if4.rob_commit_i[0] = mk(1'b1, 1'b0, 1'b1, 32'h0000_0100);
        if4.rob_commit_i[1] = mk(1'b1, 1'b0, 1'b0, 32'h0);
        if4.rob_commit_i[2] = mk(1'b1, 1'b0, 1'b0, 32'h0);
        if4.rob_commit_i[3] = mk(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("fl4.T", 64'(if4.commit_request_o), 64'h1);
        step();
        if4.rob_commit_i[0] = mk(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("fl4.T1flush", 64'(if4.flush_o), 64'h1);
        chk("fl4.T1pc", 64'(if4.redirect_pc_o), 64'h100);
        chk("fl4.T1req", 64'(if4.commit_request_o), 64'h0);
        step();
        @(negedge clk);
        chk("fl4.T2req", 64'(if4.commit_request_o), 64'hF);
        chk("fl4.T2flush", 64'(if4.flush_o), 64'h0);
        step();
        clr_all();

        // Flush held off by a three-cycle stall, width 1.
        if1.rob_commit_i[0] = mk(1'b1, 1'b0, 1'b1, 32'h2000_0000);
        if1.commit_ready_i  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("st1.req", 64'(if1.commit_request_o), 64'h0);
            chk("st1.flush", 64'(if1.flush_o), 64'h0);
            step();
        end
        if1.commit_ready_i = 1'b1;
        @(negedge clk);
        chk("st1.go", 64'(if1.commit_request_o), 64'h1);
        step();
        clr_all();
        @(negedge clk);
        chk("st1.flush", 64'(if1.flush_o), 64'h1);
        chk("st1.pc", 64'(if1.redirect_pc_o), 64'h2000_0000);
        step();
        step();

        // Prefix table, width 4.
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < 4; k++) begin
                if4.rob_commit_i[k] = mk(tbl[i].v[k], tbl[i].fc[k],
                                         tbl[i].fr[k], 32'h0);
            end
            if4.commit_ready_i = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d", i), 64'(if4.commit_request_o),
                64'(tbl[i].exp));
            step();
        end
        clr_all();

        // Reset in the middle of a drain window.
        if2.rob_commit_i[0] = mk(1'b1, 1'b0, 1'b1, 32'h0000_0F00);
        step();
        clr_all();
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rd.flush", 64'(if2.flush_o), 64'h0);
        chk("rd.pc", 64'(if2.redirect_pc_o), 64'h0);
        chk("rd.cnt", if2.retire_cnt_o, 64'h0);
        step();
        rst = 1'b0;
        if2.rob_commit_i[0] = mk(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("rd.req", 64'(if2.commit_request_o), 64'h1);
        chk("rd.noflush", 64'(if2.flush_o), 64'h0);
        step();
        clr_all();
        @(negedge clk);
        chk("rd.noflush2", 64'(if2.flush_o), 64'h0);
        chk("rd.cnt1", if2.retire_cnt_o, 64'd1);
        step();
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
